// File: rtl/div_clk_monitor.sv
// div_clk_monitor
//   Downstream checker for the divided-clock generators. Samples a divided clock
//   in the i_clk domain, aligns a fixed measurement window to its first rising
//   edge, counts rising edges and high samples over the window, and grades the
//   edge count against an expected value. A gap counter flags a stuck clock.
//
//   Optional build macro: DIV_MON_SYNC_EN
//     defined   -> i_div_clk passes through a 2-flop synchroniser (async sources);
//                  all edge-relative timing moves out by 2 cycles.
//     undefined -> i_div_clk is sampled directly and must be clk-derived.
//
// Ports
//   i_clk       system clock, all logic on posedge
//   i_rst       synchronous active-high reset
//   i_start     measurement request, accepted only when idle
//   i_div_clk   divided clock under test
//   o_busy      high while arming or measuring
//   o_done      one-cycle pulse when results are valid
//   o_edge_cnt  rising edges counted in the window
//   o_high_cnt  cycles the divided clock was sampled high in the window
//   o_pass      edge count within EXP_EDGES +/- TOL and not stuck
//   o_fail_lo   edge count below EXP_EDGES-TOL (floor 0)
//   o_fail_hi   edge count above EXP_EDGES+TOL
//   o_stuck     no rising edge for STUCK_LIM cycles while busy

module div_clk_monitor #(
  parameter int WINDOW    = 48,
  parameter int CNT_W     = 8,
  parameter int EXP_EDGES = 16,
  parameter int TOL       = 1,
  parameter int STUCK_LIM = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_div_clk,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_edge_cnt,
  output logic [CNT_W-1:0] o_high_cnt,
  output logic             o_pass,
  output logic             o_fail_lo,
  output logic             o_fail_hi,
  output logic             o_stuck
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE, S_DONE} state_t;

  // Grading thresholds are one bit wider than the counters so a negative
  // lower bound clamps to zero instead of wrapping.
  localparam int              LO_INT    = EXP_EDGES - TOL;
  localparam logic [CNT_W:0]  C_LO      = (LO_INT < 0) ? '0 : (CNT_W+1)'(LO_INT);
  localparam logic [CNT_W:0]  C_HI      = (CNT_W+1)'(EXP_EDGES + TOL);
  localparam logic [CNT_W-1:0] C_WINDOW = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] C_STUCK  = CNT_W'(STUCK_LIM);

  state_t           r_state, w_state_nxt;
  logic             r_prev;
  logic [CNT_W-1:0] r_edge_cnt, w_edge_nxt;
  logic [CNT_W-1:0] r_high_cnt, w_high_nxt;
  logic [CNT_W-1:0] r_win_cnt, w_win_nxt;
  logic [CNT_W-1:0] r_gap_cnt, w_gap_nxt;
  logic             r_done, w_done_nxt;
  logic             r_pass, w_pass_nxt;
  logic             r_fail_lo, w_fail_lo_nxt;
  logic             r_fail_hi, w_fail_hi_nxt;
  logic             r_stuck, w_stuck_nxt;
  logic             w_s;
  logic             w_rise;
  logic             w_finish;
  logic [CNT_W-1:0] w_final_edge;
  logic [CNT_W:0]   w_final_ext;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != '1)) return v + 1'b1;
    return v;
  endfunction

`ifdef DIV_MON_SYNC_EN
  logic r_sync1, r_sync2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_div_clk;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = i_div_clk;
`endif

  assign w_rise = w_s & ~r_prev;

  always_comb begin
    w_state_nxt  = r_state;
    w_edge_nxt   = r_edge_cnt;
    w_high_nxt   = r_high_cnt;
    w_win_nxt    = r_win_cnt;
    w_gap_nxt    = r_gap_cnt;
    w_done_nxt   = 1'b0;
    w_stuck_nxt  = r_stuck;
    w_pass_nxt   = r_pass;
    w_fail_lo_nxt = r_fail_lo;
    w_fail_hi_nxt = r_fail_hi;
    w_finish     = 1'b0;
    w_final_edge = r_edge_cnt;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt   = S_ARM;
          w_edge_nxt    = '0;
          w_high_nxt    = '0;
          w_win_nxt     = '0;
          w_gap_nxt     = '0;
          w_stuck_nxt   = 1'b0;
          w_pass_nxt    = 1'b0;
          w_fail_lo_nxt = 1'b0;
          w_fail_hi_nxt = 1'b0;
        end
      end

      // The aligning rise is itself window cycle 1.
      S_ARM: begin
        if (w_rise) begin
          w_state_nxt = S_MEASURE;
          w_gap_nxt   = '0;
          w_edge_nxt  = CNT_W'(1);
          w_high_nxt  = CNT_W'(1);
          w_win_nxt   = CNT_W'(1);
        end else begin
          w_gap_nxt = satInc(r_gap_cnt, 1'b1);
          if (w_gap_nxt >= C_STUCK) begin
            w_stuck_nxt  = 1'b1;
            w_finish     = 1'b1;
            w_final_edge = r_edge_cnt;
          end
        end
      end

      // Stuck wins over the last window sample; a stuck finish leaves the
      // counters as they were before this cycle.
      S_MEASURE: begin
        w_gap_nxt = w_rise ? '0 : satInc(r_gap_cnt, 1'b1);
        if (!w_rise && (w_gap_nxt >= C_STUCK)) begin
          w_stuck_nxt  = 1'b1;
          w_finish     = 1'b1;
          w_final_edge = r_edge_cnt;
        end else begin
          w_edge_nxt = satInc(r_edge_cnt, w_rise);
          w_high_nxt = satInc(r_high_cnt, w_s);
          w_win_nxt  = satInc(r_win_cnt, 1'b1);
          if (w_win_nxt >= C_WINDOW) begin
            w_finish     = 1'b1;
            w_final_edge = w_edge_nxt;
          end
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_final_ext = {1'b0, w_final_edge};
    if (w_finish) begin
      w_state_nxt   = S_DONE;
      w_done_nxt    = 1'b1;
      w_fail_lo_nxt = (w_final_ext < C_LO);
      w_fail_hi_nxt = (w_final_ext > C_HI);
      w_pass_nxt    = !(w_final_ext < C_LO) && !(w_final_ext > C_HI) && !w_stuck_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_prev     <= 1'b0;
      r_edge_cnt <= '0;
      r_high_cnt <= '0;
      r_win_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail_lo  <= 1'b0;
      r_fail_hi  <= 1'b0;
      r_stuck    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_prev     <= w_s;
      r_edge_cnt <= w_edge_nxt;
      r_high_cnt <= w_high_nxt;
      r_win_cnt  <= w_win_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_done     <= w_done_nxt;
      r_pass     <= w_pass_nxt;
      r_fail_lo  <= w_fail_lo_nxt;
      r_fail_hi  <= w_fail_hi_nxt;
      r_stuck    <= w_stuck_nxt;
    end
  end

  assign o_busy     = (r_state == S_ARM) || (r_state == S_MEASURE);
  assign o_done     = r_done;
  assign o_edge_cnt = r_edge_cnt;
  assign o_high_cnt = r_high_cnt;
  assign o_pass     = r_pass;
  assign o_fail_lo  = r_fail_lo;
  assign o_fail_hi  = r_fail_hi;
  assign o_stuck    = r_stuck;

endmodule

// File: tb/tb_div_clk_monitor.sv
// tb_div_clk_monitor
//   Directed bench for div_clk_monitor with default parameters. Inputs change on
//   the falling edge and outputs are read on the following falling edge, so each
//   applyStimulus call corresponds to exactly one rising edge of the DUT.

module tb_div_clk_monitor;

  logic       clk;
  logic       rst;
  logic       start;
  logic       divClk;
  logic       busy;
  logic       done;
  logic [7:0] edgeCnt;
  logic [7:0] highCnt;
  logic       pass;
  logic       failLo;
  logic       failHi;
  logic       stuck;

  int checkCount = 0;
  int errorCount = 0;

  div_clk_monitor dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_div_clk  (divClk),
    .o_busy     (busy),
    .o_done     (done),
    .o_edge_cnt (edgeCnt),
    .o_high_cnt (highCnt),
    .o_pass     (pass),
    .o_fail_lo  (failLo),
    .o_fail_hi  (failHi),
    .o_stuck    (stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs, let one rising edge pass, return at the falling edge.
  task automatic applyStimulus(input logic divVal, input logic startVal);
    divClk = divVal;
    start  = startVal;
    @(negedge clk);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Start a measurement, then drive a periodic pattern (highLen ones per period).
  // After (holdAfter-1) full periods the clock is held high; 0 disables that.
  // doneAt is the number of pattern cycles until done was seen, -1 on timeout.
  task automatic runMeasure(input int period, input int highLen, input int holdAfter,
                            input int reStartAt, input int budget,
                            output int doneAt, output int busyAtStart);
    logic v;
    applyStimulus(1'b0, 1'b1);
    busyAtStart = busy;
    doneAt = -1;
    for (int c = 0; c < budget; c++) begin
      v = ((c % period) < highLen);
      if ((holdAfter > 0) && (c >= (holdAfter - 1) * period)) v = 1'b1;
      applyStimulus(v, c == reStartAt);
      if (done) begin
        doneAt = c + 1;
        break;
      end
    end
  endtask

  int doneAt;
  int busyAtStart;
  int doneSeen;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    divClk = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    checkOutput("resetBusy",  busy, 0);
    checkOutput("resetDone",  done, 0);
    checkOutput("resetEdges", edgeCnt, 0);
    checkOutput("resetHighs", highCnt, 0);
    checkOutput("resetPass",  pass, 0);
    checkOutput("resetStuck", stuck, 0);

    // Period 3, 1,1,0: nominal divide-by-3.
    runMeasure(3, 2, 0, -1, 80, doneAt, busyAtStart);
    checkOutput("p3BusyAtStart", busyAtStart, 1);
    checkOutput("p3DoneAt",  doneAt, 48);
    checkOutput("p3Edges",   edgeCnt, 16);
    checkOutput("p3Highs",   highCnt, 32);
    checkOutput("p3Pass",    pass, 1);
    checkOutput("p3FailLo",  failLo, 0);
    checkOutput("p3FailHi",  failHi, 0);
    checkOutput("p3Stuck",   stuck, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("p3DonePulse", done, 0);
    checkOutput("p3BusyAfter", busy, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("p3PassHeld",  pass, 1);
    checkOutput("p3EdgesHeld", edgeCnt, 16);

    // Period 4, 1,1,0,0: too slow.
    runMeasure(4, 2, 0, -1, 80, doneAt, busyAtStart);
    checkOutput("p4DoneAt", doneAt, 48);
    checkOutput("p4Edges",  edgeCnt, 12);
    checkOutput("p4Highs",  highCnt, 24);
    checkOutput("p4FailLo", failLo, 1);
    checkOutput("p4FailHi", failHi, 0);
    checkOutput("p4Pass",   pass, 0);
    applyStimulus(1'b0, 1'b0);

    // Period 2, 1,0: too fast.
    runMeasure(2, 1, 0, -1, 80, doneAt, busyAtStart);
    checkOutput("p2DoneAt", doneAt, 48);
    checkOutput("p2Edges",  edgeCnt, 24);
    checkOutput("p2Highs",  highCnt, 24);
    checkOutput("p2FailHi", failHi, 1);
    checkOutput("p2FailLo", failLo, 0);
    checkOutput("p2Pass",   pass, 0);
    applyStimulus(1'b0, 1'b0);

    // Clock held low: stuck while arming.
    runMeasure(1, 0, 0, -1, 40, doneAt, busyAtStart);
    checkOutput("lowDoneAt", doneAt, 16);
    checkOutput("lowStuck",  stuck, 1);
    checkOutput("lowEdges",  edgeCnt, 0);
    checkOutput("lowPass",   pass, 0);
    checkOutput("lowFailLo", failLo, 1);
    applyStimulus(1'b0, 1'b0);

    // Period 3 that stops high after its 10th rising edge: stuck mid-window.
    runMeasure(3, 2, 10, -1, 80, doneAt, busyAtStart);
    checkOutput("stopDoneAt", doneAt, 44);
    checkOutput("stopStuck",  stuck, 1);
    checkOutput("stopEdges",  edgeCnt, 10);
    checkOutput("stopFailLo", failLo, 1);
    checkOutput("stopFailHi", failHi, 0);
    checkOutput("stopPass",   pass, 0);
    applyStimulus(1'b0, 1'b0);

    // Reset in the middle of a measurement.
    applyStimulus(1'b0, 1'b1);
    for (int c = 0; c < 20; c++) applyStimulus((c % 3) < 2, 1'b0);
    checkOutput("midBusy", busy, 1);
    checkOutput("midEdges", edgeCnt, 7);
    divClk = 1'b1;
    applyReset();
    checkOutput("rstBusy",  busy, 0);
    checkOutput("rstEdges", edgeCnt, 0);
    checkOutput("rstHighs", highCnt, 0);
    checkOutput("rstStuck", stuck, 0);
    doneSeen = 0;
    for (int c = 0; c < 60; c++) begin
      applyStimulus((c % 3) < 2, 1'b0);
      if (done || busy) doneSeen++;
    end
    checkOutput("rstNoDone", doneSeen, 0);

    // Start re-issued while arming, then again during the done cycle: both ignored.
    runMeasure(1, 0, 0, 5, 40, doneAt, busyAtStart);
    checkOutput("reStartDoneAt", doneAt, 16);
    checkOutput("reStartStuck",  stuck, 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("doneStartBusy", busy, 0);
    checkOutput("doneStartDone", done, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("idleAfterBusy", busy, 0);
    checkOutput("idleStuckHeld", stuck, 1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
